// File: rtl/bsg_nasti_req_serializer.sv
// Serializes one tunnel request word into LINK_WIDTH-bit beats (LSB beat
// first) on a valid/ready link, gated by a credit counter that mirrors the
// free word slots in the remote receive buffer.
module bsg_nasti_req_serializer #(
  parameter int unsigned REQ_WIDTH  = 80,
  parameter int unsigned LINK_WIDTH = 16,
  parameter int unsigned CREDITS    = 4
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  input  logic                               req_valid_i,
  input  logic [REQ_WIDTH-1:0]               req_data_i,
  output logic                               req_yumi_o,
  output logic                               link_valid_o,
  output logic [LINK_WIDTH-1:0]              link_data_o,
  input  logic                               link_ready_i,
  input  logic                               credit_return_i,
  output logic [$clog2(CREDITS+1)-1:0]       credit_avail_o,
  output logic                               credit_ovf_o
);

  localparam int unsigned NUM_BEATS  = (REQ_WIDTH + LINK_WIDTH - 1) / LINK_WIDTH;
  localparam int unsigned PAD_WIDTH  = NUM_BEATS * LINK_WIDTH;
  localparam int unsigned CNT_WIDTH  = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int unsigned CRED_WIDTH = $clog2(CREDITS + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]            state,    state_n;
  logic [PAD_WIDTH-1:0]  shreg,    shreg_n;
  logic [CNT_WIDTH-1:0]  beat_cnt, beat_cnt_n;
  logic [CRED_WIDTH-1:0] credits,  credits_n;
  logic                  ovf,      ovf_n;

  logic beat_fire;
  logic last_fire;
  logic can_load;
  logic yumi;

  // Next-state, datapath and credit bookkeeping
  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    beat_cnt_n = beat_cnt;
    credits_n  = credits;
    ovf_n      = ovf;

    beat_fire = (state == SEND) && link_ready_i;
    last_fire = beat_fire && (beat_cnt == CNT_WIDTH'(NUM_BEATS - 1));
    // Registered credit count only: a same-cycle return cannot unblock a load
    can_load  = req_valid_i && (credits != '0);
    yumi      = reset_i && can_load && ((state == IDLE) || last_fire);

    case (state)
      IDLE: begin
        if (yumi) begin
          shreg_n    = PAD_WIDTH'(req_data_i);
          beat_cnt_n = '0;
          state_n    = SEND;
        end
      end
      SEND: begin
        if (beat_fire) begin
          shreg_n    = shreg >> LINK_WIDTH;
          beat_cnt_n = beat_cnt + CNT_WIDTH'(1);
          if (last_fire) begin
            if (yumi) begin
              // Zero-bubble hand-off to the next word
              shreg_n    = PAD_WIDTH'(req_data_i);
              beat_cnt_n = '0;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (credit_return_i && !yumi) begin
      if (credits == CRED_WIDTH'(CREDITS)) ovf_n = 1'b1;
      else                                  credits_n = credits + CRED_WIDTH'(1);
    end else if (yumi && !credit_return_i) begin
      credits_n = credits - CRED_WIDTH'(1);
    end
  end

  // State register; reset aborts any partially sent word
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state    <= IDLE;
      shreg    <= '0;
      beat_cnt <= '0;
      credits  <= CRED_WIDTH'(CREDITS);
      ovf      <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      beat_cnt <= beat_cnt_n;
      credits  <= credits_n;
      ovf      <= ovf_n;
    end
  end

  assign req_yumi_o     = yumi;
  assign link_valid_o   = (state == SEND);
  assign link_data_o    = shreg[LINK_WIDTH-1:0];
  assign credit_avail_o = credits;
  assign credit_ovf_o   = ovf;

endmodule

// File: tb/tb_bsg_nasti_req_serializer.sv
// Randomized and directed bench for bsg_nasti_req_serializer; a queue of
// pending beats plus a credit integer predicts every output each cycle.
module tb_bsg_nasti_req_serializer;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic        reset_i;
  logic        req_valid, link_ready, credit_return;
  logic [79:0] req_data;
  logic        yumi, link_valid, ovf;
  logic [15:0] link_data;
  logic [2:0]  credit_avail;

  logic        req_valid70;
  logic [69:0] req_data70;
  logic        yumi70, link_valid70, ovf70;
  logic [15:0] link_data70;
  logic [2:0]  credit_avail70;

  bsg_nasti_req_serializer u_dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid), .req_data_i(req_data), .req_yumi_o(yumi),
    .link_valid_o(link_valid), .link_data_o(link_data), .link_ready_i(link_ready),
    .credit_return_i(credit_return), .credit_avail_o(credit_avail), .credit_ovf_o(ovf)
  );

  bsg_nasti_req_serializer #(.REQ_WIDTH(70), .LINK_WIDTH(16), .CREDITS(4)) u_dut70 (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid70), .req_data_i(req_data70), .req_yumi_o(yumi70),
    .link_valid_o(link_valid70), .link_data_o(link_data70), .link_ready_i(1'b1),
    .credit_return_i(1'b0), .credit_avail_o(credit_avail70), .credit_ovf_o(ovf70)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: beats still owed for the in-flight word(s), credits, overflow flag
  logic [15:0] q[$];
  int          cred = 4;
  bit          ovf_m = 1'b0;

  // Values sampled in the most recent cycle, for directed literal checks
  logic        obs_yumi, obs_valid, obs_ovf, obs70_yumi, obs70_valid;
  logic [15:0] obs_data, obs70_data;
  logic [2:0]  obs_cred;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive at negedge, compare mid-cycle, advance model at posedge
  task automatic cycle(input logic rst, input logic rv, input logic [79:0] rd,
                       input logic lr, input logic cr);
    logic exp_y;
    reset_i = rst; req_valid = rv; req_data = rd; link_ready = lr; credit_return = cr;
    if (!rst) begin
      q.delete(); cred = 4; ovf_m = 1'b0;
    end
    #1;
    exp_y = rst && rv && (cred > 0) && ((q.size() == 0) || (q.size() == 1 && lr));
    obs_yumi = yumi; obs_valid = link_valid; obs_data = link_data;
    obs_cred = credit_avail; obs_ovf = ovf;
    obs70_yumi = yumi70; obs70_valid = link_valid70; obs70_data = link_data70;
    chk("yumi", 32'(yumi), 32'(exp_y));
    chk("link_valid", 32'(link_valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("link_data", 32'(link_data), 32'(q[0]));
    else               chk("idle_data", 32'(link_data), 32'(0));
    chk("credit_avail", 32'(credit_avail), 32'(cred));
    chk("credit_ovf", 32'(ovf), 32'(ovf_m));
    @(posedge clk_i);
    if (rst) begin
      if (q.size() != 0 && lr) void'(q.pop_front());
      if (exp_y) for (int i = 0; i < 5; i++) q.push_back(rd[i*16 +: 16]);
      if (cr && !exp_y) begin
        if (cred == 4) ovf_m = 1'b1;
        else           cred++;
      end else if (exp_y && !cr) begin
        cred--;
      end
    end
    @(negedge clk_i);
  endtask

  logic [79:0] w1, w2, wr;
  logic [95:0] rnd;
  logic [15:0] e2 [5];
  logic [15:0] e70 [5];

  initial begin
    reset_i = 1'b0; req_valid = 1'b0; req_data = '0; link_ready = 1'b0; credit_return = 1'b0;
    req_valid70 = 1'b0; req_data70 = '0;
    w1 = 80'h0123_4567_89AB_CDEF_1357;
    w2 = 80'hFEDC_BA98_7654_3210_ACE1;
    e2  = '{16'h1357, 16'hCDEF, 16'h89AB, 16'h4567, 16'h0123};
    e70 = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h003F};
    @(negedge clk_i);

    // Reset state
    cycle(1'b0, 1'b1, w1, 1'b1, 1'b0);
    chk("rst_yumi", 32'(obs_yumi), 32'(0));
    chk("rst_credits", 32'(obs_cred), 32'(4));
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Single word beats in order, then back-to-back second word
    cycle(1'b1, 1'b1, w1, 1'b1, 1'b0);
    chk("t2_yumi", 32'(obs_yumi), 32'(1));
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, (i == 4), w2, 1'b1, 1'b0);
      chk("t2_beat", 32'(obs_data), 32'(e2[i]));
      if (i == 0) chk("t2_credits", 32'(obs_cred), 32'(3));
      if (i == 4) chk("t2_b2b_yumi", 32'(obs_yumi), 32'(1));
    end
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t5_no_bubble", 32'(obs_valid), 32'(1));
    chk("t5_next_beat0", 32'(obs_data), 32'h0000_ACE1);
    chk("t5_credits", 32'(obs_cred), 32'(2));
    repeat (5) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);

    // 70-bit word: five beats, last beat zero-padded above bit 5
    req_valid70 = 1'b1; req_data70 = '1;
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t3_yumi", 32'(obs70_yumi), 32'(1));
    req_valid70 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
      chk("t3_valid", 32'(obs70_valid), 32'(1));
      chk("t3_beat", 32'(obs70_data), 32'(e70[i]));
    end
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t3_done", 32'(obs70_valid), 32'(0));

    // Credit exhaustion and return
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 25; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      cycle(1'b1, 1'b1, rnd[79:0], 1'b1, 1'b0);
    end
    chk("t4_credits0", 32'(obs_cred), 32'(0));
    chk("t4_no_yumi", 32'(obs_yumi), 32'(0));
    cycle(1'b1, 1'b1, w1, 1'b1, 1'b1);
    chk("t4_ret_same_cycle", 32'(obs_yumi), 32'(0));
    cycle(1'b1, 1'b1, w1, 1'b1, 1'b0);
    chk("t4_yumi_after_ret", 32'(obs_yumi), 32'(1));
    chk("t4_credits1", 32'(obs_cred), 32'(1));
    repeat (4) cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t4_refilled", 32'(obs_cred), 32'(4));

    // Return coincident with yumi, then overflow
    cycle(1'b1, 1'b1, w2, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t6_unchanged", 32'(obs_cred), 32'(4));
    chk("t6_no_ovf", 32'(obs_ovf), 32'(0));
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t6_saturate", 32'(obs_cred), 32'(4));
    chk("t6_ovf", 32'(obs_ovf), 32'(1));
    repeat (3) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t6_ovf_sticky", 32'(obs_ovf), 32'(1));

    // Reset during beat 2 of a word
    cycle(1'b1, 1'b1, w1, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, w2, 1'b1, 1'b0);
    chk("t1_valid", 32'(obs_valid), 32'(0));
    chk("t1_credits", 32'(obs_cred), 32'(4));
    chk("t1_ovf", 32'(obs_ovf), 32'(0));
    chk("t1_yumi", 32'(obs_yumi), 32'(0));
    cycle(1'b1, 1'b1, w2, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    chk("t1_restart_beat0", 32'(obs_data), 32'h0000_ACE1);

    // Random traffic with stalls and sporadic credit returns
    for (int i = 0; i < 800; i++) begin
      rnd = {$urandom, $urandom, $urandom};
      wr  = rnd[79:0];
      cycle(1'b1, 1'($urandom_range(0, 1)), wr, 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 5) == 0));
    end
    repeat (12) cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
